// File: rtl/rotate_left_seq_if.sv
// Handshake bundle for the sequential left rotator: operand/amount request
// side and result response side, each with its own valid/ready pair.
interface rotate_left_seq_if #(
    parameter int OPERAND_WIDTH = 16,
    parameter int SHAMT_WIDTH   = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [OPERAND_WIDTH-1:0] In;
    logic [SHAMT_WIDTH-1:0]   ShAmt;
    logic                     out_valid;
    logic                     out_ready;
    logic [OPERAND_WIDTH-1:0] result;

    // Producer/consumer side of the rotator.
    modport master (
        output in_valid,
        output In,
        output ShAmt,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result
    );

    // Rotator side.
    modport slave (
        input  in_valid,
        input  In,
        input  ShAmt,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result
    );
endinterface

// File: rtl/rotate_left_seq.sv
// Multi-cycle left rotator. One logarithmic stage (1, 2, 4, 8, ...) is applied
// per clock regardless of the amount, so latency is fixed at SHAMT_WIDTH
// cycles from the accept edge. The finished value is held until the consumer
// takes it; result keeps that value until the next operand is accepted.
module rotate_left_seq #(
    parameter int OPERAND_WIDTH = 16,
    parameter int SHAMT_WIDTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    rotate_left_seq_if.slave   bus
);

    localparam int CNT_W = (SHAMT_WIDTH > 1) ? $clog2(SHAMT_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [CNT_W-1:0]         count_r;
    logic [CNT_W-1:0]         count_nxt_s;
    logic [SHAMT_WIDTH-1:0]   shamt_r;
    logic [SHAMT_WIDTH-1:0]   shamt_nxt_s;
    logic [OPERAND_WIDTH-1:0] result_r;
    logic [OPERAND_WIDTH-1:0] result_nxt_s;
    logic                     in_ready_r;
    logic                     in_ready_nxt_s;
    logic                     out_valid_r;
    logic                     out_valid_nxt_s;

    // Rotate left by 2**stage: the upper half of the doubled word shifted
    // left holds the bits that wrapped from the MSB back to the LSB.
    function automatic logic [OPERAND_WIDTH-1:0] rotl_stage(
        input logic [OPERAND_WIDTH-1:0] value,
        input logic [CNT_W-1:0]         stage
    );
        logic [2*OPERAND_WIDTH-1:0] dbl;
        dbl = {value, value} << (32'd1 << stage);
        return dbl[2*OPERAND_WIDTH-1:OPERAND_WIDTH];
    endfunction

    // Next-state and next-output logic; handshake outputs are computed here
    // and registered so in_ready/out_valid come straight from flops.
    always_comb begin
        state_nxt_s     = state_r;
        count_nxt_s     = count_r;
        shamt_nxt_s     = shamt_r;
        result_nxt_s    = result_r;
        in_ready_nxt_s  = in_ready_r;
        out_valid_nxt_s = out_valid_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    result_nxt_s    = bus.In;
                    shamt_nxt_s     = bus.ShAmt;
                    count_nxt_s     = {CNT_W{1'b0}};
                    state_nxt_s     = ROTATE;
                    in_ready_nxt_s  = 1'b0;
                    out_valid_nxt_s = 1'b0;
                end else begin
                    in_ready_nxt_s  = 1'b1;
                    out_valid_nxt_s = 1'b0;
                end
            end
            ROTATE: begin
                if (shamt_r[count_r]) begin
                    result_nxt_s = rotl_stage(result_r, count_r);
                end else begin
                    result_nxt_s = result_r;
                end
                count_nxt_s = count_r + CNT_W'(1);
                if (count_r == CNT_W'(SHAMT_WIDTH - 1)) begin
                    state_nxt_s     = DONE;
                    out_valid_nxt_s = 1'b1;
                end else begin
                    state_nxt_s     = ROTATE;
                    out_valid_nxt_s = 1'b0;
                end
                in_ready_nxt_s = 1'b0;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt_s     = IDLE;
                    out_valid_nxt_s = 1'b0;
                    in_ready_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s     = DONE;
                    out_valid_nxt_s = 1'b1;
                    in_ready_nxt_s  = 1'b0;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                count_nxt_s     = {CNT_W{1'b0}};
                shamt_nxt_s     = {SHAMT_WIDTH{1'b0}};
                result_nxt_s    = {OPERAND_WIDTH{1'b0}};
                in_ready_nxt_s  = 1'b1;
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            count_r     <= {CNT_W{1'b0}};
            shamt_r     <= {SHAMT_WIDTH{1'b0}};
            result_r    <= {OPERAND_WIDTH{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            count_r     <= count_nxt_s;
            shamt_r     <= shamt_nxt_s;
            result_r    <= result_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;

endmodule

// File: tb/tb_rotate_left_seq.sv
// Self-checking bench for rotate_left_seq: a transaction-level reference model
// (accept -> fixed delay -> hold until taken) checked every cycle, plus
// directed literal expectations.
module tb_rotate_left_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rotate_left_seq_if #(.OPERAND_WIDTH(16), .SHAMT_WIDTH(4)) bus ();

    rotate_left_seq #(.OPERAND_WIDTH(16), .SHAMT_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rotate-left with plain arithmetic.
    function automatic logic [15:0] rotl_ref(input logic [15:0] v, input int s);
        logic [31:0] w;
        w = {16'h0000, v} << s;
        return w[15:0] | w[31:16];
    endfunction

    // Transaction model: 0 idle, 1 busy (fixed countdown), 2 result waiting.
    int          m_state = 0;
    int          m_left  = 0;
    logic [15:0] m_res   = 16'h0000;
    bit          m_acc_flag = 1'b0;
    bit          m_seen  = 1'b0;
    bit          m_prev_valid = 1'b0;
    int          m_last  = 0;
    int          m_gap   = 0;
    int          cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state      <= 0;
            m_left       <= 0;
            m_res        <= 16'h0000;
            m_acc_flag   <= 1'b0;
            m_seen       <= 1'b0;
            m_prev_valid <= 1'b0;
        end else begin
            m_acc_flag <= 1'b0;
            case (m_state)
                0: if (bus.in_valid) begin
                    m_state      <= 1;
                    m_left       <= 4;
                    m_res        <= rotl_ref(bus.In, int'(bus.ShAmt));
                    m_acc_flag   <= 1'b1;
                    m_gap        <= cyc - m_last;
                    m_last       <= cyc;
                    m_prev_valid <= m_seen;
                    m_seen       <= 1'b1;
                end
                1: begin
                    if (m_left == 1) m_state <= 2;
                    m_left <= m_left - 1;
                end
                2: if (bus.out_ready) m_state <= 0;
                default: m_state <= 0;
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (m_state == 0)});
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, (m_state == 2)});
        if (m_state != 1) chk("result", {16'd0, bus.result}, {16'd0, m_res});
        if (m_acc_flag && m_prev_valid) chk("issue_gap", {31'd0, (m_gap >= 6)}, 32'd1);
    end

    // One operation: issue, optionally stall the consumer, return result and latency.
    task automatic do_op(input logic [15:0] a, input logic [3:0] s, input int stall,
                         output logic [15:0] res, output int lat);
        int t;
        @(negedge clk);
        t = 0;
        while (!bus.in_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) chk("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = (stall == 0);
        bus.In        = a;
        bus.ShAmt     = s;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.In       = 16'($urandom);
        bus.ShAmt    = 4'($urandom);
        lat = 0;
        res = 16'h0000;
        t   = 0;
        while (t < 50) begin
            @(negedge clk);
            t++;
            if (bus.out_valid) break;
        end
        if (t >= 50) chk("out_valid_timeout", {31'd0, bus.out_valid}, 32'd1);
        lat = t - 1;
        res = bus.result;
        if (stall > 0) begin
            repeat (stall - 1) @(negedge clk);
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    logic [15:0] r;
    int          lat;
    int          pulses;

    typedef struct { logic [15:0] a; logic [3:0] s; logic [15:0] exp; } vec_t;
    vec_t vecs[5];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.In        = 16'h0000;
        bus.ShAmt     = 4'd0;
        bus.out_ready = 1'b0;

        // Reset values, then release.
        repeat (2) @(negedge clk);
        chk("rst_result", {16'd0, bus.result}, 32'h0000);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Basic amounts, consumer always ready.
        vecs[0] = '{16'hB38F, 4'd0,  16'hB38F};
        vecs[1] = '{16'hB38F, 4'd1,  16'h671F};
        vecs[2] = '{16'hB38F, 4'd4,  16'h38FB};
        vecs[3] = '{16'hB38F, 4'd8,  16'h8FB3};
        vecs[4] = '{16'hB38F, 4'd15, 16'hD9C7};
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].s, 0, r, lat);
            chk($sformatf("basic_sh%0d", vecs[i].s), {16'd0, r}, {16'd0, vecs[i].exp});
            chk($sformatf("latency_sh%0d", vecs[i].s), lat, 32'd4);
            @(negedge clk);
            chk("one_cycle_valid", {31'd0, bus.out_valid}, 32'd0);
        end

        // Backpressure with ignored in_valid pulses during DONE.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.In        = 16'hB38F;
        bus.ShAmt     = 4'd2;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_result", {16'd0, bus.result}, 32'h0000CE3E);
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            bus.in_valid = (i % 2 == 0);
            bus.In       = 16'h1234;
            bus.ShAmt    = 4'd7;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Input changes and in_valid pulses during ROTATE are ignored.
        bus.In       = 16'h0001;
        bus.ShAmt    = 4'd3;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.In       = 16'hFFFF;
        bus.ShAmt    = 4'd5;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                pulses++;
                chk("busy_result", {16'd0, bus.result}, 32'h00000008);
            end
        end
        chk("busy_pulses", pulses, 32'd1);

        // Mid-cycle reset while a result is held in DONE.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.In        = 16'h00F0;
        bus.ShAmt     = 4'd4;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_result", {16'd0, bus.result}, 32'h0000);
        chk("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;

        // Reset mid-ROTATE discards the operation.
        @(negedge clk);
        bus.In       = 16'hB38F;
        bus.ShAmt    = 4'd15;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midop_rst_result", {16'd0, bus.result}, 32'h0000);
        chk("midop_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midop_no_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        do_op(16'h8000, 4'd1, 0, r, lat);
        chk("after_rst_op", {16'd0, r}, 32'h00000001);

        // Random operands with random consumer stalls.
        for (int i = 0; i < 200; i++) begin
            logic [15:0] a;
            logic [3:0]  s;
            a = 16'($urandom);
            s = 4'($urandom_range(0, 15));
            do_op(a, s, int'($urandom_range(0, 3)), r, lat);
            chk("rand_result", {16'd0, r}, {16'd0, rotl_ref(a, int'(s))});
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rotate_left_seq.md
# rotate_left_seq

Multi-cycle left rotator: the opposite direction of the team's combinational right rotator, built as a sequential unit with valid/ready handshakes on both sides. It accepts one operand and rotate amount, applies one logarithmic rotate stage per clock (1, 2, 4, 8, …), then holds the result until the consumer takes it. It sits beside the ALU shifter block in the execute stage, for ROL-class instructions that can tolerate a fixed multi-cycle latency.

## Interface
- OPERAND_WIDTH, 16: data width; must equal 2**SHAMT_WIDTH.
- SHAMT_WIDTH, 4: rotate-amount width; also the number of rotate stages and cycles.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  producer presents In/ShAmt.
- in_ready  output  1  block can accept; high only in IDLE.
- In  input  OPERAND_WIDTH  operand to rotate left.
- ShAmt  input  SHAMT_WIDTH  rotate-left amount, 0..OPERAND_WIDTH-1.
- out_valid  output  1  result holds the finished rotation.
- out_ready  input  1  consumer accepts the result.
- result  output  OPERAND_WIDTH  working/result register.

## Operation
- States: IDLE, ROTATE, DONE. Reset forces IDLE, result=0, stage counter=0, captured shamt=0, in_ready=1, out_valid=0.
- IDLE: in_ready=1. When in_valid=1 at an edge: result<=In, shamt_q<=ShAmt, count<=0, state->ROTATE.
- ROTATE: in_ready=0, out_valid=0. Each edge: if shamt_q[count]=1, result<=result rotated left by 2**count (bits leaving the MSB re-enter at the LSB); otherwise result is unchanged. count increments. The edge that processes count=SHAMT_WIDTH-1 moves the state to DONE.
- DONE: out_valid=1, result stable. When out_ready=1 at an edge: state->IDLE. result keeps its value until the next accept.
- Net effect: result = (In << ShAmt) | (In >> (OPERAND_WIDTH-ShAmt)), taken modulo OPERAND_WIDTH. ShAmt=0 passes In through unchanged but still takes the full latency.
- in_valid outside IDLE is ignored, and In/ShAmt changes after the accept edge have no effect.
- The producer must hold In/ShAmt stable only on the edge where in_valid and in_ready are both high.

## Timing
- Accept edge A0 (in_valid and in_ready both high). Stages run on edges A1..A(SHAMT_WIDTH). out_valid rises after edge A(SHAMT_WIDTH), i.e. 4 cycles after the accept edge for the defaults.
- Latency is fixed and independent of ShAmt.
- out_valid stays high, with result constant, for as many cycles as out_ready stays low.
- If out_ready is already high when DONE is entered, the handshake completes at the first DONE edge, so out_valid lasts exactly 1 cycle.
- in_ready returns high the cycle after the output handshake. Minimum issue interval is SHAMT_WIDTH+2 cycles (6 for the defaults).
- The input and output handshakes never complete on the same edge.
- rst asserted at any point, including mid-ROTATE or DONE: outputs go to their reset values immediately, without waiting for a clock edge, and the in-flight operation is discarded. The first accept is possible on the first edge after rst deasserts.

## Test plan
- Reset: assert rst mid-cycle -> immediately result=0, out_valid=0, in_ready=1. After release, in_ready=1.
- Basic amounts, In=16'hB38F, out_ready held high:
  - ShAmt=0 -> 16'hB38F
  - ShAmt=1 -> 16'h671F
  - ShAmt=4 -> 16'h38FB
  - ShAmt=8 -> 16'h8FB3
  - ShAmt=15 -> 16'hD9C7
  - Each: out_valid high exactly 4 cycles after the accept edge, for 1 cycle.
- Backpressure: ShAmt=2, out_ready=0 for 5 cycles -> out_valid and result=16'hCE3E held steady for all 5 cycles. in_ready stays 0 and in_valid pulses meanwhile are ignored. Raising out_ready completes the handshake, and in_ready=1 the next cycle.
- Input ignored while busy: accept In=16'h0001, ShAmt=3; change In/ShAmt and pulse in_valid during ROTATE -> result=16'h0008, and only one out_valid pulse.
- Reset mid-operation: accept In=16'hB38F, ShAmt=15; assert rst after edge A2 -> result=0 and out_valid never rises. Next op In=16'h8000, ShAmt=1 -> 16'h0001.
- Back-to-back random: 200 random In/ShAmt pairs with random out_ready stalls -> every result matches the reference rotate-left model, and issue interval is at least 6 cycles.
